// File: rtl/mac_rx_dequeue_pkg.sv
// Shared definitions for the MAC receive dequeue block: pointer field
// layout, FSM state encoding, frame length defaults and the skid word.
package mac_rx_dequeue_pkg;

    localparam int PTR_W    = 20;
    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 11;
    localparam int ERR_BIT  = 11;
    localparam int META_LSB = 12;
    localparam int META_W   = 8;

    localparam int DEF_MIN_LEN         = 60;
    localparam int DEF_MAX_LEN         = 1518;
    localparam int DEF_BE_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PTR  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // One byte of the output stream together with its framing tags.
    typedef struct packed {
        logic       tte;
        logic       eop;
        logic       sop;
        logic [7:0] data;
    } skid_word_t;

    localparam int SKID_W = $bits(skid_word_t);

endpackage

// File: rtl/mac_rx_skid_buf.sv
// Two-entry registered valid/ready buffer. The producer is trusted to push
// only when a slot is (or is becoming) free; o_free reports empty slots.
module mac_rx_skid_buf
    import mac_rx_dequeue_pkg::*;
#(
    parameter int W = SKID_W
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_free
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign o_valid = (r_count != 2'd0);
    assign w_pop   = o_valid & i_ready;
    assign w_push  = i_push & ((r_count != 2'd2) | w_pop);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_free  = 2'd2 - r_count;

    // Storage, pointers and occupancy; a flush clears everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/mac_rx_dequeue.sv
// Pops frame pointers from the TTE and best-effort queues, streams the
// frame bytes out through a 2-entry skid buffer, drops bad frames.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | frame boundary; arbitrate and pop one pointer
//  PTR     | pointer word valid; classify frame, issue first data read
//  FWD     | read remaining bytes while the skid buffer has room
//  DROP    | read remaining bytes one per cycle and discard them
module mac_rx_dequeue
    import mac_rx_dequeue_pkg::*;
#(
    parameter int MAX_LEN         = DEF_MAX_LEN,
    parameter int MIN_LEN         = DEF_MIN_LEN,
    parameter int BE_STARVE_LIMIT = DEF_BE_STARVE_LIMIT
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tteptr_fifo_empty,
    output logic              o_tteptr_fifo_rd,
    input  logic [PTR_W-1:0]  i_tteptr_fifo_dout,
    output logic              o_tte_fifo_rd,
    input  logic [7:0]        i_tte_fifo_dout,
    input  logic              i_ptr_fifo_empty,
    output logic              o_ptr_fifo_rd,
    input  logic [PTR_W-1:0]  i_ptr_fifo_dout,
    output logic              o_data_fifo_rd,
    input  logic [7:0]        i_data_fifo_dout,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [7:0]        o_out_data,
    output logic              o_out_sop,
    output logic              o_out_eop,
    output logic              o_out_tte,
    output logic [META_W-1:0] o_out_meta,
    output logic [15:0]       o_cnt_fwd,
    output logic [15:0]       o_cnt_drop
);

    localparam logic [LEN_W-1:0] L_MIN    = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] L_MAX    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] L_ONE    = LEN_W'(1);
    localparam logic [15:0]      L_STARVE = 16'(BE_STARVE_LIMIT);

    state_t              r_state;
    state_t              w_next;
    logic                r_src_tte;
    logic [LEN_W-1:0]    r_remain;
    logic                r_first;
    logic [META_W-1:0]   r_meta_q;
    logic [META_W-1:0]   r_meta_hold;
    logic                r_inflight;
    logic                r_inf_sop;
    logic                r_inf_eop;
    logic                r_inf_tte;
    logic                r_sop_pend;
    logic [15:0]         r_starve;
    logic [15:0]         r_cnt_fwd;
    logic [15:0]         r_cnt_drop;

    logic [PTR_W-1:0]    w_ptr;
    logic [LEN_W-1:0]    w_len;
    logic                w_err;
    logic [META_W-1:0]   w_meta;
    logic                w_bad;
    logic [LEN_W-1:0]    w_cur_remain;
    logic                w_cur_first;
    logic                w_room;
    logic                w_tte_ok;
    logic                w_grant_tte;
    logic                w_grant_be;
    logic                w_data_rd;
    logic                w_is_fwd;
    logic                w_fwd_rd;
    logic                w_drop_evt;
    logic                w_skid_valid;
    logic                w_pop;
    logic [1:0]          w_free;
    skid_word_t          w_push_word;
    skid_word_t          w_head_word;

    assign w_ptr  = r_src_tte ? i_tteptr_fifo_dout : i_ptr_fifo_dout;
    assign w_len  = w_ptr[LEN_LSB +: LEN_W];
    assign w_err  = w_ptr[ERR_BIT];
    assign w_meta = w_ptr[META_LSB +: META_W];
    assign w_bad  = w_err | (w_len < L_MIN) | (w_len > L_MAX);

    // In PTR the frame context is still on the FIFO output, not in registers.
    assign w_cur_remain = (r_state == ST_PTR) ? w_len : r_remain;
    assign w_cur_first  = (r_state == ST_PTR) | r_first;

    assign w_pop = w_skid_valid & i_out_ready;
    // Room for one more read: occupancy plus the read in flight, less the
    // byte leaving this cycle, must stay below the two slots.
    assign w_room = ({1'b0, w_free} + {2'b00, w_pop}) > {2'b00, r_inflight};

    assign w_tte_ok = ~i_tteptr_fifo_empty &
                      (i_ptr_fifo_empty | (L_STARVE == 16'd0) | (r_starve < L_STARVE));

    assign w_fwd_rd = w_data_rd & w_is_fwd;

    // Next-state, pointer pops and data reads.
    always_comb begin
        w_next      = r_state;
        w_grant_tte = 1'b0;
        w_grant_be  = 1'b0;
        w_data_rd   = 1'b0;
        w_is_fwd    = 1'b0;
        w_drop_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A pending SOP keeps the next frame's metadata from
                // overwriting the one still needed at the output.
                if (!i_rst && !r_sop_pend) begin
                    if (w_tte_ok) begin
                        w_grant_tte = 1'b1;
                        w_next      = ST_PTR;
                    end else if (!i_ptr_fifo_empty) begin
                        w_grant_be = 1'b1;
                        w_next     = ST_PTR;
                    end
                end
            end
            ST_PTR: begin
                if (w_len == '0) begin
                    w_drop_evt = 1'b1;
                    w_next     = ST_IDLE;
                end else if (w_bad) begin
                    w_data_rd = 1'b1;
                    if (w_len == L_ONE) begin
                        w_drop_evt = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_next = ST_DROP;
                    end
                end else begin
                    w_is_fwd = 1'b1;
                    w_next   = ST_FWD;
                    if (w_room) begin
                        w_data_rd = 1'b1;
                        if (w_len == L_ONE) begin
                            w_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_FWD: begin
                w_is_fwd = 1'b1;
                if (w_room) begin
                    w_data_rd = 1'b1;
                    if (r_remain == L_ONE) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                w_data_rd = 1'b1;
                if (r_remain == L_ONE) begin
                    w_drop_evt = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_tteptr_fifo_rd = w_grant_tte;
    assign o_ptr_fifo_rd    = w_grant_be;
    assign o_tte_fifo_rd    = w_data_rd & r_src_tte;
    assign o_data_fifo_rd   = w_data_rd & ~r_src_tte;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame context: source queue, bytes still to read, first-byte flag, metadata.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src_tte <= 1'b0;
            r_remain  <= '0;
            r_first   <= 1'b0;
            r_meta_q  <= '0;
        end else begin
            if (w_grant_tte | w_grant_be) begin
                r_src_tte <= w_grant_tte;
            end
            if (r_state == ST_PTR) begin
                r_remain <= w_len - LEN_W'(w_data_rd);
                r_first  <= ~w_data_rd;
                r_meta_q <= w_meta;
            end else if (w_data_rd) begin
                r_remain <= r_remain - L_ONE;
                r_first  <= 1'b0;
            end
        end
    end

    // Tags of the forwarded read whose byte appears on the FIFO output next cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_inf_sop  <= 1'b0;
            r_inf_eop  <= 1'b0;
            r_inf_tte  <= 1'b0;
        end else begin
            r_inflight <= w_fwd_rd;
            r_inf_sop  <= w_cur_first;
            r_inf_eop  <= (w_cur_remain == L_ONE);
            r_inf_tte  <= r_src_tte;
        end
    end

    assign w_push_word.tte  = r_inf_tte;
    assign w_push_word.eop  = r_inf_eop;
    assign w_push_word.sop  = r_inf_sop;
    assign w_push_word.data = r_inf_tte ? i_tte_fifo_dout : i_data_fifo_dout;

    mac_rx_skid_buf #(
        .W (SKID_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_data  (w_push_word),
        .o_valid (w_skid_valid),
        .i_ready (i_out_ready),
        .o_data  (w_head_word),
        .o_free  (w_free)
    );

    // SOP-pending flag and the metadata held for the rest of the current frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sop_pend  <= 1'b0;
            r_meta_hold <= '0;
        end else begin
            if (w_fwd_rd && w_cur_first) begin
                r_sop_pend <= 1'b1;
            end else if (w_pop && w_head_word.sop) begin
                r_sop_pend <= 1'b0;
            end
            if (w_pop && w_head_word.sop) begin
                r_meta_hold <= r_meta_q;
            end
        end
    end

    // Best-effort starvation counter, saturating.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (w_grant_tte) begin
            if (i_ptr_fifo_empty) begin
                r_starve <= '0;
            end else if (r_starve != 16'hFFFF) begin
                r_starve <= r_starve + 16'd1;
            end
        end else if (w_grant_be) begin
            r_starve <= '0;
        end
    end

    // Forwarded and dropped frame counters, wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_fwd  <= '0;
            r_cnt_drop <= '0;
        end else begin
            if (w_pop && w_head_word.eop) begin
                r_cnt_fwd <= r_cnt_fwd + 16'd1;
            end
            if (w_drop_evt) begin
                r_cnt_drop <= r_cnt_drop + 16'd1;
            end
        end
    end

    assign o_out_valid = w_skid_valid;
    assign o_out_data  = w_head_word.data;
    assign o_out_sop   = w_head_word.sop;
    assign o_out_eop   = w_head_word.eop;
    assign o_out_tte   = w_head_word.tte;
    assign o_out_meta  = w_skid_valid ? (w_head_word.sop ? r_meta_q : r_meta_hold) : '0;
    assign o_cnt_fwd   = r_cnt_fwd;
    assign o_cnt_drop  = r_cnt_drop;

endmodule

// File: tb/tb_mac_rx_dequeue.sv
// Directed bench for mac_rx_dequeue: FIFO models feed pointers and bytes,
// a monitor captures accepted bytes, expected values are hand-computed.
module tb_mac_rx_dequeue;

    logic        clk = 1'b0;
    logic        rst;
    logic        tp_empty, tp_rd, td_rd, bp_empty, bp_rd, bd_rd;
    logic [19:0] tp_dout = '0, bp_dout = '0;
    logic [7:0]  td_dout = '0, bd_dout = '0;
    logic        out_valid, out_ready, out_sop, out_eop, out_tte;
    logic [7:0]  out_data, out_meta;
    logic [15:0] cnt_fwd, cnt_drop;

    always #5 clk = ~clk;

    mac_rx_dequeue #(
        .MAX_LEN         (1518),
        .MIN_LEN         (60),
        .BE_STARVE_LIMIT (2)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_tteptr_fifo_empty (tp_empty),
        .o_tteptr_fifo_rd    (tp_rd),
        .i_tteptr_fifo_dout  (tp_dout),
        .o_tte_fifo_rd       (td_rd),
        .i_tte_fifo_dout     (td_dout),
        .i_ptr_fifo_empty    (bp_empty),
        .o_ptr_fifo_rd       (bp_rd),
        .i_ptr_fifo_dout     (bp_dout),
        .o_data_fifo_rd      (bd_rd),
        .i_data_fifo_dout    (bd_dout),
        .o_out_valid         (out_valid),
        .i_out_ready         (out_ready),
        .o_out_data          (out_data),
        .o_out_sop           (out_sop),
        .o_out_eop           (out_eop),
        .o_out_tte           (out_tte),
        .o_out_meta          (out_meta),
        .o_cnt_fwd           (cnt_fwd),
        .o_cnt_drop          (cnt_drop)
    );

    // FIFO models: write index owned by the stimulus, read index by the model.
    logic [19:0] tp_mem [64];
    logic [19:0] bp_mem [64];
    logic [7:0]  td_mem [4096];
    logic [7:0]  bd_mem [8192];
    int tp_wr = 0, tp_rx = 0, bp_wr = 0, bp_rx = 0;
    int td_wr = 0, td_rx = 0, bd_wr = 0, bd_rx = 0;
    int rd_empty_err = 0;

    assign tp_empty = (tp_wr == tp_rx);
    assign bp_empty = (bp_wr == bp_rx);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_rx <= tp_wr; bp_rx <= bp_wr; td_rx <= td_wr; bd_rx <= bd_wr;
        end else begin
            if (tp_rd) begin
                if (tp_wr == tp_rx) rd_empty_err <= rd_empty_err + 1;
                else begin tp_dout <= tp_mem[tp_rx]; tp_rx <= tp_rx + 1; end
            end
            if (bp_rd) begin
                if (bp_wr == bp_rx) rd_empty_err <= rd_empty_err + 1;
                else begin bp_dout <= bp_mem[bp_rx]; bp_rx <= bp_rx + 1; end
            end
            if (td_rd) begin
                if (td_wr == td_rx) rd_empty_err <= rd_empty_err + 1;
                else begin td_dout <= td_mem[td_rx]; td_rx <= td_rx + 1; end
            end
            if (bd_rd) begin
                if (bd_wr == bd_rx) rd_empty_err <= rd_empty_err + 1;
                else begin bd_dout <= bd_mem[bd_rx]; bd_rx <= bd_rx + 1; end
            end
        end
    end

    // Monitor: capture accepted bytes, count reads, watch stall stability.
    logic [7:0]  cap_d [1024];
    logic [7:0]  cap_m [1024];
    logic        cap_s [1024];
    logic        cap_e [1024];
    logic        cap_t [1024];
    int          cap_n = 0;
    int          td_rd_n = 0, bd_rd_n = 0, acc_n = 0;
    int          stab_err = 0, max_infl = 0;
    int          base_rd = 0, base_acc = 0;
    logic        measure_on = 1'b0;
    logic        prev_stall = 1'b0;
    logic [19:0] prev_vec = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({out_valid, out_data, out_sop, out_eop, out_tte, out_meta} != prev_vec))
                stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_vec   = {out_valid, out_data, out_sop, out_eop, out_tte, out_meta};
            if (out_valid && out_ready) begin
                cap_d[cap_n] = out_data; cap_m[cap_n] = out_meta;
                cap_s[cap_n] = out_sop;  cap_e[cap_n] = out_eop; cap_t[cap_n] = out_tte;
                cap_n++;
                acc_n++;
            end
            if (td_rd) td_rd_n++;
            if (bd_rd) bd_rd_n++;
            if (measure_on) begin
                if (((td_rd_n + bd_rd_n - base_rd) - (acc_n - base_acc)) > max_infl)
                    max_infl = (td_rd_n + bd_rd_n - base_rd) - (acc_n - base_acc);
            end
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_bytes(input bit tte, input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) begin
            if (tte) begin td_mem[td_wr] = start + 8'(i); td_wr++; end
            else     begin bd_mem[bd_wr] = start + 8'(i); bd_wr++; end
        end
    endtask

    task automatic push_ptr(input bit tte, input logic [7:0] meta, input bit err, input logic [10:0] len);
        if (tte) begin tp_mem[tp_wr] = {meta, err, len}; tp_wr++; end
        else     begin bp_mem[bp_wr] = {meta, err, len}; bp_wr++; end
    endtask

    task automatic wait_cnt(input string tag, input int fwd, input int drop, input int budget);
        int n = 0;
        while ((cnt_fwd != 16'(fwd) || cnt_drop != 16'(drop)) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, "_cnt_fwd"}, 32'(cnt_fwd), fwd);
        check_val({tag, "_cnt_drop"}, 32'(cnt_drop), drop);
    endtask

    task automatic verify_frame(input string tag, input int base, input int n,
                                input logic [7:0] start, input logic [7:0] meta, input logic tte);
        int nd = 0, nf = 0, nm = 0, nt = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_d[base+i] !== start + 8'(i)) nd++;
            if (cap_s[base+i] !== (i == 0) || cap_e[base+i] !== (i == n-1)) nf++;
            if (cap_m[base+i] !== meta) nm++;
            if (cap_t[base+i] !== tte) nt++;
        end
        check_val({tag, "_data_errs"}, nd, 0);
        check_val({tag, "_sop_eop_errs"}, nf, 0);
        check_val({tag, "_meta_errs"}, nm, 0);
        check_val({tag, "_tte_errs"}, nt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rd0;
        rst = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_cnt_fwd", cnt_fwd, 0);
        check_val("rst_cnt_drop", cnt_drop, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single good BE frame, latency and content.
        out_ready = 1'b1;
        base = cap_n;
        push_bytes(0, 64, 8'h00);
        push_ptr(0, 8'h5A, 0, 11'd64);
        repeat (2) @(posedge clk);
        #1;
        check_val("lat_cycle2_valid", out_valid, 0);
        @(posedge clk); #1;
        check_val("lat_cycle3_valid", out_valid, 1);
        check_val("lat_cycle3_sop", out_sop, 1);
        wait_cnt("t1", 1, 0, 300);
        check_val("t1_bytes", cap_n - base, 64);
        verify_frame("t1", base, 64, 8'h00, 8'h5A, 1'b0);

        // Strict priority with anti-starvation limit 2.
        base = cap_n;
        for (int k = 0; k < 4; k++) push_bytes(1, 60, 8'(k * 64));
        push_bytes(0, 60, 8'h20);
        for (int k = 0; k < 4; k++) push_ptr(1, 8'hA0 + 8'(k), 0, 11'd60);
        push_ptr(0, 8'hB0, 0, 11'd60);
        wait_cnt("t2", 6, 0, 1000);
        check_val("t2_bytes", cap_n - base, 300);
        verify_frame("t2_f0_tte", base,       60, 8'h00, 8'hA0, 1'b1);
        verify_frame("t2_f1_tte", base + 60,  60, 8'h40, 8'hA1, 1'b1);
        verify_frame("t2_f2_be",  base + 120, 60, 8'h20, 8'hB0, 1'b0);
        verify_frame("t2_f3_tte", base + 180, 60, 8'h80, 8'hA2, 1'b1);
        verify_frame("t2_f4_tte", base + 240, 60, 8'hC0, 8'hA3, 1'b1);

        // Errored frame drained silently, then a good frame.
        base = cap_n;
        rd0 = bd_rd_n;
        push_bytes(0, 100, 8'h00);
        push_bytes(0, 60, 8'h80);
        push_ptr(0, 8'h11, 1, 11'd100);
        push_ptr(0, 8'h22, 0, 11'd60);
        wait_cnt("t3", 7, 1, 600);
        check_val("t3_be_reads", bd_rd_n - rd0, 160);
        check_val("t3_bytes", cap_n - base, 60);
        verify_frame("t3", base, 60, 8'h80, 8'h22, 1'b0);

        // Illegal lengths 59, 1519 and 0.
        base = cap_n;
        rd0 = bd_rd_n;
        push_bytes(0, 59, 8'h00);
        push_bytes(0, 1519, 8'h00);
        push_ptr(0, 8'h01, 0, 11'd59);
        push_ptr(0, 8'h02, 0, 11'd1519);
        push_ptr(0, 8'h03, 0, 11'd0);
        wait_cnt("t4", 7, 4, 3000);
        check_val("t4_be_reads", bd_rd_n - rd0, 1578);
        check_val("t4_bytes", cap_n - base, 0);

        // Random backpressure.
        base = cap_n;
        base_rd = td_rd_n + bd_rd_n;
        base_acc = acc_n;
        measure_on = 1'b1;
        push_bytes(0, 64, 8'h30);
        push_ptr(0, 8'h77, 0, 11'd64);
        for (int i = 0; i < 2000 && cnt_fwd != 16'd8; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        wait_cnt("t5", 8, 4, 100);
        measure_on = 1'b0;
        check_val("t5_bytes", cap_n - base, 64);
        verify_frame("t5", base, 64, 8'h30, 8'h77, 1'b0);
        check_val("t5_stall_stability_errs", stab_err, 0);
        check_val("t5_inflight_le2", 32'(max_infl <= 2), 1);

        // Reset in the middle of a frame.
        base = cap_n;
        push_bytes(0, 64, 8'h00);
        push_ptr(0, 8'h44, 0, 11'd64);
        for (int i = 0; i < 200 && (cap_n - base) < 30; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", out_valid, 0);
        check_val("t6_rst_data", out_data, 0);
        check_val("t6_rst_flags", {out_sop, out_eop, out_tte}, 0);
        check_val("t6_rst_meta", out_meta, 0);
        check_val("t6_rst_rds", {tp_rd, td_rd, bp_rd, bd_rd}, 0);
        check_val("t6_rst_cnt_fwd", cnt_fwd, 0);
        check_val("t6_rst_cnt_drop", cnt_drop, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = cap_n;
        push_bytes(0, 60, 8'h90);
        push_ptr(0, 8'h33, 0, 11'd60);
        wait_cnt("t6", 1, 0, 300);
        check_val("t6_bytes", cap_n - base, 60);
        verify_frame("t6", base, 60, 8'h90, 8'h33, 1'b0);

        check_val("rd_on_empty", rd_empty_err, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
